// File: rtl/sprite_pkg.sv
// Shared types and helpers for the runtime-writable sprite palette.
// Default widths here seed the parameters of sprite_palette_ram.
package sprite_pkg;

   localparam int IDX_W_D   = 8;
   localparam int COLOR_W_D = 4;
   localparam int FADE_W_D  = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pal_state_t;

   typedef struct packed {
      logic [COLOR_W_D-1:0] r;
      logic [COLOR_W_D-1:0] g;
      logic [COLOR_W_D-1:0] b;
   } rgb_t;

   // Wide operands let any COLOR_W/FADE_W pair use it; caller truncates.
   function automatic logic [31:0] fade_channel(input logic [31:0] c,
                                                input logic [31:0] level,
                                                input int unsigned fade_w);
      return (c * (level + 32'd1)) >> fade_w;
   endfunction

endpackage

// File: rtl/palette_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module palette_mem #(
   parameter int AW = 10,
   parameter int DW = 12
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_palette_ram.sv
// Multi-bank sprite palette: clear-on-reset storage, 2-stage lookup with
// transparency keying and a per-frame brightness fade.
module sprite_palette_ram
   import sprite_pkg::*;
#(
   parameter int IDX_W           = IDX_W_D,
   parameter int COLOR_W         = COLOR_W_D,
   parameter int NUM_BANKS       = 4,
   parameter int TRANSPARENT_IDX = 0,
   parameter int FADE_W          = FADE_W_D
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_rd_valid,
   input  logic [$clog2(NUM_BANKS)-1:0] i_rd_bank,
   input  logic [IDX_W-1:0]             i_rd_index,
   output logic                         o_out_valid,
   output logic [COLOR_W-1:0]           o_red,
   output logic [COLOR_W-1:0]           o_green,
   output logic [COLOR_W-1:0]           o_blue,
   output logic                         o_transparent,
   input  logic                         i_wr_valid,
   output logic                         o_wr_ready,
   input  logic [$clog2(NUM_BANKS)-1:0] i_wr_bank,
   input  logic [IDX_W-1:0]             i_wr_index,
   input  logic [3*COLOR_W-1:0]         i_wr_rgb,
   input  logic                         i_frame_start,
   input  logic [FADE_W-1:0]            i_fade_level,
   output logic                         o_init_done
);

   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int AW     = BANK_W + IDX_W;
   localparam int DW     = 3*COLOR_W;
   localparam logic [AW-1:0] LAST_ADDR = AW'((NUM_BANKS << IDX_W) - 1);

   pal_state_t          r_state;
   logic [AW-1:0]       r_clr_addr;
   logic                r_wr_ready;
   logic                r_init_done;
   logic [FADE_W-1:0]   r_fade_q;
   logic [1:0]          r_vld_pipe;
   logic                r_s1_key;
   logic                r_s1_init;
   logic [COLOR_W-1:0]  r_red, r_green, r_blue;
   logic                r_transp;

   logic                w_we;
   logic [AW-1:0]       w_waddr;
   logic [DW-1:0]       w_wdata;
   logic [DW-1:0]       w_rdata;
   logic [COLOR_W-1:0]  w_red, w_green, w_blue;

   // INIT owns the write port to clear storage; user writes wait on wr_ready.
   assign w_we    = (r_state == ST_INIT) | (i_wr_valid & r_wr_ready);
   assign w_waddr = (r_state == ST_INIT) ? r_clr_addr : {i_wr_bank, i_wr_index};
   assign w_wdata = (r_state == ST_INIT) ? '0 : i_wr_rgb;

   palette_mem #(.AW(AW), .DW(DW)) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr ({i_rd_bank, i_rd_index}),
      .o_rdata (w_rdata)
   );

   assign w_red   = COLOR_W'(fade_channel(32'(w_rdata[DW-1 -: COLOR_W]), 32'(r_fade_q), FADE_W));
   assign w_green = COLOR_W'(fade_channel(32'(w_rdata[2*COLOR_W-1 -: COLOR_W]), 32'(r_fade_q), FADE_W));
   assign w_blue  = COLOR_W'(fade_channel(32'(w_rdata[COLOR_W-1:0]), 32'(r_fade_q), FADE_W));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_INIT;
         r_clr_addr  <= '0;
         r_wr_ready  <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == LAST_ADDR) begin
                  r_state     <= ST_RUN;
                  r_wr_ready  <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fade_q   <= '1;
         r_vld_pipe <= '0;
         r_s1_key   <= 1'b0;
         r_s1_init  <= 1'b0;
         r_red      <= '0;
         r_green    <= '0;
         r_blue     <= '0;
         r_transp   <= 1'b0;
      end else begin
         if (i_frame_start) r_fade_q <= i_fade_level;
         r_vld_pipe <= {r_vld_pipe[0], i_rd_valid};
         if (i_rd_valid) begin
            r_s1_key  <= (i_rd_index == IDX_W'(TRANSPARENT_IDX));
            // Storage may still hold power-up garbage while clearing.
            r_s1_init <= (r_state == ST_INIT);
         end
         if (r_vld_pipe[0]) begin
            r_transp <= r_s1_key;
            if (r_s1_key || r_s1_init) begin
               r_red   <= '0;
               r_green <= '0;
               r_blue  <= '0;
            end else begin
               r_red   <= w_red;
               r_green <= w_green;
               r_blue  <= w_blue;
            end
         end
      end
   end

   assign o_out_valid   = r_vld_pipe[1];
   assign o_red         = r_red;
   assign o_green       = r_green;
   assign o_blue        = r_blue;
   assign o_transparent = r_transp;
   assign o_wr_ready    = r_wr_ready;
   assign o_init_done   = r_init_done;

endmodule

// File: doc/sprite_palette_ram.md
Name: sprite_palette_ram

Overview:
Runtime-writable, multi-bank sprite palette that replaces the fixed per-sprite palette ROMs. It maps a per-pixel colour index plus a bank select to 12-bit RGB (4 bits per channel). Lookup is a 2-stage pipeline with transparency keying and a per-frame brightness fade. It sits between the sprite ROM index outputs and the VGA colour mux, and the game logic writes it through a valid/ready port, for example to recolour tank turrets per player.

Parameters:
IDX_W, 8, colour-index width; 2**IDX_W entries per bank
COLOR_W, 4, bits per colour channel
NUM_BANKS, 4, number of independent palettes (power of two, >=2)
TRANSPARENT_IDX, 0, index that is always reported transparent
FADE_W, 4, brightness-level width

Ports:
Clk  in  1  system clock; all logic is on the rising edge
Reset_n  in  1  asynchronous active-low reset
rd_valid  in  1  lookup request this cycle
rd_bank  in  $clog2(NUM_BANKS)  palette bank for lookup
rd_index  in  IDX_W  colour index for lookup
out_valid  out  1  lookup result valid; rd_valid delayed 2 cycles
red  out  COLOR_W  faded red channel
green  out  COLOR_W  faded green channel
blue  out  COLOR_W  faded blue channel
transparent  out  1  pixel is transparent (rgb is forced to 0)
wr_valid  in  1  write request
wr_ready  out  1  write can be accepted
wr_bank  in  $clog2(NUM_BANKS)  bank to write
wr_index  in  IDX_W  entry to write
wr_rgb  in  3*COLOR_W  {r,g,b} colour to store
frame_start  in  1  single-cycle pulse at start of frame; samples fade_level
fade_level  in  FADE_W  brightness level; all-ones means full brightness
init_done  out  1  high once the power-up clear has completed

Behaviour:
- Storage: NUM_BANKS*2**IDX_W words of 3*COLOR_W bits. Address = {bank, index}. Inferred as synchronous block RAM; storage has no reset.
- FSM states: INIT, RUN.
- Reset: asserting Reset_n=0 immediately sets state=INIT, clr_addr=0, fade_q=all-ones, pipeline valids=0, out_valid=0, red/green/blue=0, transparent=0, wr_ready=0, init_done=0.
- INIT:
  - Writes 0 to address clr_addr each cycle and increments it.
  - After the last address (NUM_BANKS*2**IDX_W-1) is written, moves to RUN on the next edge. INIT lasts exactly NUM_BANKS*2**IDX_W cycles.
  - wr_ready=0, so user writes stall.
  - Lookups during INIT still pipeline and return rgb=0.
- RUN:
  - wr_ready=1 and init_done=1.
  - A write occurs when wr_valid&&wr_ready, one per cycle, and takes effect at that edge.
- Reset mid-INIT or mid-RUN: the clear sequence restarts from address 0. Contents written before the reset are not guaranteed after the clear.
- Lookup pipeline, with rd_valid in cycle N:
  - Stage 1 (edge N): RAM read, and bank/index/valid registered.
  - Stage 2 (edge N+1): fade and key applied, and outputs registered.
  - Outputs are valid in cycle N+2. Throughput is 1 per cycle, with no back-pressure.
- Read/write collision on the same address in the same cycle: the read returns the OLD data (read-before-write). The following read returns the new data.
- Transparency:
  - If the stage-1 index equals TRANSPARENT_IDX, then transparent=1 and rgb=0, in any bank, whatever is stored.
  - Otherwise transparent=0.
- Fade:
  - Each channel out = (c * (fade_q+1)) >> FADE_W, computed with a COLOR_W+FADE_W+1 bit intermediate, with no rounding.
  - fade_q=all-ones gives the identity. fade_q=0 gives c>>FADE_W, which is 0 for COLOR_W=4.
- fade_q loads fade_level only when frame_start=1. This is allowed in any state, so fade is constant within a frame.
- When out_valid=0, red/green/blue/transparent hold their last values. Consumers must qualify with out_valid.

Decomposition:
- Shared package sprite_pkg:
  - rgb_t, a packed struct {r,g,b} of COLOR_W each.
  - Default COLOR_W and IDX_W constants.
  - Function fade_channel(c, level).
- One natural sub-module: palette_mem, a simple dual-port RAM with one write port and one registered read port, read-before-write.
- The FSM, pipeline and fade logic stay in sprite_palette_ram.

Test Plan:
1. Reset_n low 3 cycles, then high → init_done=0, wr_ready=0 for exactly 1024 cycles (defaults), then both 1. Any lookup afterwards returns rgb=0, with transparent=1 only for index 0.
2. After init, write bank1 idx 0x05 = 0x782. Lookup bank1 idx 0x05 in cycle N → out_valid=1 in N+2 with {r,g,b}={7,8,2}. Bank0 idx 0x05 still returns 000.
3. Write bank2 idx 0x00 = 0xABC, then look it up → transparent=1, rgb=000.
4. Pulse frame_start with fade_level=7, then look up the entry holding 0xA6 for r,b (0xAB6) → r=(10*8)>>4=5, g=(11*8)>>4=5, b=(6*8)>>4=3. Change fade_level without frame_start → output unchanged.
5. Same-cycle write 0x111 and read of bank3 idx 0x20 (old 0x222) → result 0x222. Next-cycle read → 0x111.
6. Assert Reset_n low for 1 cycle mid-stream in RUN with back-to-back lookups → out_valid drops immediately, wr_ready=0, and INIT runs the full 1024 cycles again.
